set_alarm: RTL and testbench
============================

# set_alarm

Alarm-time entry block for the digital clock. While enabled, it steps the user through three fields in order: alarm on/off, hours, then minutes. A mode button advances the field and an increment button edits it. The stored alarm time is held as BCD digits for the display and comparator, and the on/off state drives the alarm comparator; both are kept when the block is disabled. A completion flag tells the top-level controller that setting is finished.

## Interface
- No parameters.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high; clears all state on the clock edge where it is sampled 1.
- set_alarm_en  in  1  set-alarm mode enable from the top-level controller.
- mode_button  in  1  advance-field button; debounced and synchronized upstream.
- inc_button  in  1  increment/toggle button; debounced and synchronized upstream.
- o_hours_left  out  2  hours tens digit, BCD 0–2.
- o_hours_right  out  4  hours units digit, BCD 0–9.
- o_minutes_left  out  3  minutes tens digit, BCD 0–5.
- o_minutes_right  out  4  minutes units digit, BCD 0–9.
- ack_flag  out  1  setting sequence complete.
- on_off_alarm  out  1  alarm armed (1) / disarmed (0).

## Operation
- Button events:
  - Each button is rising-edge detected against its own registered previous value.
  - An event fires on the edge where the button is sampled 1 and its previous value is 0.
  - A held button produces exactly one event.
- FSM states: S_ONOFF, S_HOURS, S_MINUTES, S_DONE.
- Transitions on a mode event while set_alarm_en=1:
  - S_ONOFF→S_HOURS
  - S_HOURS→S_MINUTES
  - S_MINUTES→S_DONE
  - S_DONE stays in S_DONE.
- Inc events while set_alarm_en=1:
  - S_ONOFF: toggle on_off_alarm.
  - S_HOURS: hours +1, wraps 23→00.
  - S_MINUTES: minutes +1, wraps 59→00.
  - S_DONE: ignored.
- Simultaneous mode and inc events: mode wins; inc is discarded and nothing is edited.
- BCD arithmetic:
  - Units digit 9 rolls to 0 and carries into the tens digit.
  - Hours 23 rolls to 00 (hours_left=0, hours_right=0).
  - Minutes 59 rolls to 00.
  - Digits never hold non-BCD values.
- ack_flag is 1 exactly while the state is S_DONE.
- set_alarm_en=0:
  - State forced to S_ONOFF; ack_flag cleared.
  - Button events ignored.
  - Alarm time and on_off_alarm retained.
- Time outputs always reflect the stored alarm time, whether or not the block is enabled.

## Timing
- All outputs are registered.
- An edit appears on the outputs at the same rising edge that samples the button's first 1. There is no extra cycle of latency.
- ack_flag rises at the edge that samples the mode press that leaves S_MINUTES. It falls at the first edge that samples set_alarm_en=0.
- Minimum press spacing: button 1 for one cycle, then 0 for one cycle, gives one event per press.
- Reset values:
  - All time digits 0.
  - on_off_alarm=0, ack_flag=0.
  - State S_ONOFF.
  - Edge-detector previous values 0.
- Reset mid-sequence aborts the sequence and applies the reset values at that edge. rst has priority over all other inputs.
- After set_alarm_en rises, editing begins in S_ONOFF on the next event.

## Structure
- Shared package alarm_pkg holds:
  - State enum: S_ONOFF, S_HOURS, S_MINUTES, S_DONE.
  - Constants HOURS_MAX=23 and MINUTES_MAX=59.
  - BCD digit width constants.
- One sub-module, button_edge: a 1-bit rising-edge detector with clk and rst. Instantiate it twice, once for mode_button and once for inc_button.
- The top level contains the FSM, two BCD counters (hours and minutes), and the on/off toggle register.

## Test plan
- Reset, then release: all digits 0, on_off_alarm=0, ack_flag=0.
- Enable, one inc pulse: on_off_alarm=1. A second pulse gives on_off_alarm=0.
- Enable; inc, mode, then 20 inc pulses: on_off_alarm=1, hours 20 (o_hours_left=2, o_hours_right=0). Minutes unchanged.
- Continue with 4 more inc pulses: hours wraps to 00.
- In S_MINUTES, 60 inc pulses: minutes wraps 59→00. A single inc from 09 gives 10 (left=1, right=0).
- Full sequence (mode, 20 inc, mode, inc, mode):
  - Outputs read 20:01 and ack_flag=1 from that edge.
  - Dropping set_alarm_en clears ack_flag next edge; time and on/off are retained.
- Mode and inc high on the same cycle: state advances and no field changes.
- Holding inc high for 5 cycles gives exactly one increment.
- rst mid-edit: everything returns to reset values.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm-time entry block.
// State encoding, time limits and BCD digit widths.
package alarm_pkg;

  typedef enum logic [1:0] {
    S_ONOFF,
    S_HOURS,
    S_MINUTES,
    S_DONE
  } state_t;

  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;

  localparam int HL_W = 2;
  localparam int HR_W = 4;
  localparam int ML_W = 3;
  localparam int MR_W = 4;

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for a pre-debounced button.
// Ports: clk, rst (sync, active-high), btn in, rise out.
//   rise is high in the cycle btn is 1 and its
//   registered previous value is 0, so a held
//   button yields a single pulse.
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/set_alarm.sv
// Alarm-time entry: on/off, hours, minutes in turn.
// Ports: clk, rst, set_alarm_en, mode_button,
//   inc_button in; BCD alarm time digits,
//   ack_flag and on_off_alarm out (all registered).
module set_alarm
  import alarm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_alarm_en,
  input  logic            mode_button,
  input  logic            inc_button,
  output logic [HL_W-1:0] o_hours_left,
  output logic [HR_W-1:0] o_hours_right,
  output logic [ML_W-1:0] o_minutes_left,
  output logic [MR_W-1:0] o_minutes_right,
  output logic            ack_flag,
  output logic            on_off_alarm
);

  localparam logic [HL_W-1:0] HL_TOP =
    HL_W'(HOURS_MAX / 10);
  localparam logic [HR_W-1:0] HR_TOP =
    HR_W'(HOURS_MAX % 10);
  localparam logic [ML_W-1:0] ML_TOP =
    ML_W'(MINUTES_MAX / 10);
  localparam logic [MR_W-1:0] MR_TOP =
    MR_W'(MINUTES_MAX % 10);
  localparam logic [3:0] DIG9 = 4'd9;

  logic   mode_ev;
  logic   inc_ev;
  state_t state;

  button_edge u_mode_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (mode_button),
    .rise (mode_ev)
  );

  button_edge u_inc_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (inc_button),
    .rise (inc_ev)
  );

  // Mode outranks inc: a simultaneous inc is
  // dropped so a field is never edited on the
  // same edge it is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_ONOFF;
      ack_flag        <= 1'b0;
      on_off_alarm    <= 1'b0;
      o_hours_left    <= '0;
      o_hours_right   <= '0;
      o_minutes_left  <= '0;
      o_minutes_right <= '0;
    end else if (!set_alarm_en) begin
      state    <= S_ONOFF;
      ack_flag <= 1'b0;
    end else if (mode_ev) begin
      unique case (state)
        S_ONOFF:   state <= S_HOURS;
        S_HOURS:   state <= S_MINUTES;
        S_MINUTES: begin
          state    <= S_DONE;
          ack_flag <= 1'b1;
        end
        S_DONE:    state <= S_DONE;
      endcase
    end else if (inc_ev) begin
      unique case (state)
        S_ONOFF: on_off_alarm <= ~on_off_alarm;
        S_HOURS: begin
          if (o_hours_left == HL_TOP &&
              o_hours_right == HR_TOP) begin
            o_hours_left  <= '0;
            o_hours_right <= '0;
          end else if (o_hours_right == DIG9) begin
            o_hours_right <= '0;
            o_hours_left  <= o_hours_left + 1'b1;
          end else begin
            o_hours_right <= o_hours_right + 1'b1;
          end
        end
        S_MINUTES: begin
          if (o_minutes_left == ML_TOP &&
              o_minutes_right == MR_TOP) begin
            o_minutes_left  <= '0;
            o_minutes_right <= '0;
          end else if (o_minutes_right == DIG9) begin
            o_minutes_right <= '0;
            o_minutes_left  <= o_minutes_left + 1'b1;
          end else begin
            o_minutes_right <= o_minutes_right + 1'b1;
          end
        end
        S_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_alarm.sv
// Self-checking bench for set_alarm.
// Integer-time reference model plus literal checks.
module tb_set_alarm;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_alarm_en;
  logic       mode_button;
  logic       inc_button;
  logic [1:0] o_hours_left;
  logic [3:0] o_hours_right;
  logic [2:0] o_minutes_left;
  logic [3:0] o_minutes_right;
  logic       ack_flag;
  logic       on_off_alarm;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  // reference model: whole-number time, step index
  int m_step = 0;
  int m_hours = 0;
  int m_minutes = 0;
  bit m_on = 0;
  bit m_ack = 0;
  bit m_pm = 0;
  bit m_pi = 0;

  always #5 clk = ~clk;

  set_alarm dut (
    .clk             (clk),
    .rst             (rst),
    .set_alarm_en    (set_alarm_en),
    .mode_button     (mode_button),
    .inc_button      (inc_button),
    .o_hours_left    (o_hours_left),
    .o_hours_right   (o_hours_right),
    .o_minutes_left  (o_minutes_left),
    .o_minutes_right (o_minutes_right),
    .ack_flag        (ack_flag),
    .on_off_alarm    (on_off_alarm)
  );

  always @(posedge clk) begin
    bit me, ie;
    me = mode_button && !m_pm;
    ie = inc_button && !m_pi;
    m_pm = mode_button;
    m_pi = inc_button;
    if (rst) begin
      m_step = 0; m_hours = 0; m_minutes = 0;
      m_on = 0; m_ack = 0; m_pm = 0; m_pi = 0;
    end else if (!set_alarm_en) begin
      m_step = 0; m_ack = 0;
    end else if (me) begin
      if (m_step < 3) m_step++;
      m_ack = (m_step == 3);
    end else if (ie) begin
      if (m_step == 0) m_on = !m_on;
      else if (m_step == 1) m_hours = (m_hours + 1) % 24;
      else if (m_step == 2) m_minutes = (m_minutes + 1) % 60;
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {2'(m_hours / 10), 4'(m_hours % 10),
               3'(m_minutes / 10), 4'(m_minutes % 10),
               m_ack, m_on};
      act_v = {o_hours_left, o_hours_right,
               o_minutes_left, o_minutes_right,
               ack_flag, on_off_alarm};
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got %h exp %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic lit(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  function automatic int hh();
    return o_hours_left * 10 + o_hours_right;
  endfunction

  function automatic int mm();
    return o_minutes_left * 10 + o_minutes_right;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic p_inc();
    @(negedge clk) inc_button = 1;
    @(negedge clk) inc_button = 0;
  endtask

  task automatic p_mode();
    @(negedge clk) mode_button = 1;
    @(negedge clk) mode_button = 0;
  endtask

  task automatic n_inc(int n);
    for (int i = 0; i < n; i++) p_inc();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
  endtask

  initial begin
    rst = 1; set_alarm_en = 0;
    mode_button = 0; inc_button = 0;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    tick();
    lit("rst_hours", hh(), 0);
    lit("rst_min", mm(), 0);
    lit("rst_on", on_off_alarm, 0);
    lit("rst_ack", ack_flag, 0);

    set_alarm_en = 1;
    p_inc();
    lit("toggle_on", on_off_alarm, 1);
    p_inc();
    lit("toggle_off", on_off_alarm, 0);

    p_inc(); p_mode(); n_inc(20);
    lit("on_after", on_off_alarm, 1);
    lit("h20_left", o_hours_left, 2);
    lit("h20_right", o_hours_right, 0);
    lit("h20_min", mm(), 0);
    n_inc(4);
    lit("h_wrap", hh(), 0);

    p_mode(); n_inc(60);
    lit("m_wrap", mm(), 0);
    n_inc(9);
    lit("m09", mm(), 9);
    p_inc();
    lit("m10_left", o_minutes_left, 1);
    lit("m10_right", o_minutes_right, 0);

    do_reset();
    set_alarm_en = 1;
    p_mode(); n_inc(20); p_mode(); p_inc();
    lit("pre_ack", ack_flag, 0);
    p_mode();
    lit("seq_hours", hh(), 20);
    lit("seq_min", mm(), 1);
    lit("seq_ack", ack_flag, 1);
    p_mode();
    lit("done_stay", ack_flag, 1);
    p_inc();
    lit("done_inc", mm(), 1);
    set_alarm_en = 0;
    tick();
    lit("ack_drop", ack_flag, 0);
    lit("keep_hours", hh(), 20);
    lit("keep_min", mm(), 1);
    lit("keep_on", on_off_alarm, 0);
    p_inc(); p_mode();
    lit("dis_ign_on", on_off_alarm, 0);

    set_alarm_en = 1;
    tick();
    @(negedge clk) begin
      mode_button = 1; inc_button = 1;
    end
    @(negedge clk) begin
      mode_button = 0; inc_button = 0;
    end
    lit("both_on", on_off_alarm, 0);
    p_inc();
    lit("both_adv", hh(), 21);

    @(negedge clk) inc_button = 1;
    repeat (4) tick();
    @(negedge clk) inc_button = 0;
    lit("hold_once", hh(), 22);

    p_mode(); p_inc();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    lit("mid_rst_h", hh(), 0);
    lit("mid_rst_m", mm(), 0);
    lit("mid_rst_on", on_off_alarm, 0);
    p_inc();
    lit("post_rst_on", on_off_alarm, 1);
    tick();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
